hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: hold  in  1  external freeze request; idex_memread  in  1  ID/EX load flag; idex_rt  in  5  ID/EX rt; ifid_rs  in  5  IF/ID rs; ifid_rt  in  5  IF/ID rt.
REQ-003 SHALL have ports: exmem_branch  in  1  EX/MEM branch; exmem_zero  in  1  EX/MEM zero flag.
REQ-004 SHALL have ports: pc_write  out  1  PC load enable; ifid_write  out  1  IF/ID load enable; idex_bubble  out  1  zero ID/EX control; pc_src  out  1  select EX/MEM branch target.
REQ-005 SHALL have ports: flush_ifid  out  1; flush_idex  out  1; flush_exmem  out  1  clear respective register control fields.
REQ-006 SHALL have ports: state  out  2  RUN=00, STALL=01, FLUSH=10; stall_cnt  out  16; flush_cnt  out  16  event counters.
REQ-007 SHALL use one clock clk; reset SHALL be synchronous and active-high.

Function
REQ-008 load_use SHALL be idex_memread AND idex_rt!=0 AND (idex_rt==ifid_rs OR idex_rt==ifid_rt).
REQ-009 taken SHALL be exmem_branch AND exmem_zero.
REQ-010 Control outputs SHALL be combinational from state, hold, load_use, taken, reset; state and counters SHALL update on rising clk.
REQ-011 Default outputs: pc_write=1, ifid_write=1, idex_bubble=0, pc_src=0, all flush_*=0.
REQ-012 Priority per cycle: reset > hold > taken > load_use.
REQ-013 hold=1 (any state): pc_write=0, ifid_write=0, idex_bubble=0, pc_src=0, flush_*=0; state and counters unchanged.
REQ-014 RUN, taken: pc_src=1, flush_ifid=flush_idex=flush_exmem=1, pc_write=1; next FLUSH; flush_cnt+1.
REQ-015 RUN, load_use, not taken: pc_write=0, ifid_write=0, idex_bubble=1; next STALL; stall_cnt+1.
REQ-016 RUN, neither: defaults; stay RUN.
REQ-017 STALL: load_use ignored; taken handled as REQ-014 (to FLUSH); else defaults, next RUN.
REQ-018 FLUSH: taken and load_use both ignored; defaults; next RUN.
REQ-019 Stall/flush latency: exactly one cycle per event; back-to-back load_use SHALL be separated by >=1 non-stall cycle.
REQ-020 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-021 Encoding 11 unreachable; if entered, SHALL output defaults and return to RUN next cycle.

Reset
REQ-022 While reset=1: pc_write=0, ifid_write=0, idex_bubble=0, pc_src=0, flush_*=0 regardless of other inputs.
REQ-023 On clk edge with reset=1: state=RUN, stall_cnt=0, flush_cnt=0; reset mid-STALL/FLUSH SHALL abort the sequence.
REQ-024 First cycle after reset deassertion SHALL evaluate as RUN.

Verification
REQ-025 Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 in RUN -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; state=01 next; stall_cnt=1; RUN after.
REQ-026 r0 exclusion: idex_memread=1, idex_rt=0, ifid_rs=0 -> no stall, stall_cnt stays 0.
REQ-027 Branch vs load-use same cycle: taken=1 and load_use=1 in RUN -> pc_src=1, all flush_*=1, pc_write=1, idex_bubble=0; state=10; flush_cnt=1, stall_cnt=0.
REQ-028 FLUSH masking: taken held high two cycles -> second cycle pc_src=0, flush_*=0; flush_cnt=1; RUN on third.
REQ-029 hold: load_use=1 with hold=1 three cycles -> pc_write=0, idex_bubble=0, state RUN, stall_cnt 0; release -> stall as REQ-025.
REQ-030 Saturation/reset: force 65536 stalls -> stall_cnt=FFFF; reset in STALL -> state=00, counters 0, pc_write=0 during reset.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: hazard inputs from the
// pipeline registers and the resulting enable/flush/bubble controls.
interface hazard_ctrl_if;
    logic        hold;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        exmem_branch;
    logic        exmem_zero;

    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        pc_src;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    // master: the pipeline that supplies hazard information
    modport master (
        output hold, idex_memread, idex_rt, ifid_rs, ifid_rt,
               exmem_branch, exmem_zero,
        input  pc_write, ifid_write, idex_bubble, pc_src,
               flush_ifid, flush_idex, flush_exmem,
               state, stall_cnt, flush_cnt
    );

    // slave: the hazard controller
    modport slave (
        input  hold, idex_memread, idex_rt, ifid_rs, ifid_rt,
               exmem_branch, exmem_zero,
        output pc_write, ifid_write, idex_bubble, pc_src,
               flush_ifid, flush_idex, flush_exmem,
               state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: one-cycle load-use stall, branch-taken flush,
// external hold, and saturating stall/flush event counters.
module hazard_ctrl #(
    // Saturation ceiling of both event counters (full 16-bit range by default)
    parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       load_use;
    logic       taken;
    logic [1:0] cnt_inc;     // [0] stall event, [1] flush event

    logic pc_write_c;
    logic ifid_write_c;
    logic idex_bubble_c;
    logic pc_src_c;
    logic flush_c;

    assign load_use = bus.idex_memread && (bus.idex_rt != 5'd0) &&
                      ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
    assign taken    = bus.exmem_branch && bus.exmem_zero;

    always_comb begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        idex_bubble_c = 1'b0;
        pc_src_c      = 1'b0;
        flush_c       = 1'b0;
        cnt_inc       = 2'b00;
        state_next    = state_reg;

        if (reset) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            state_next   = ST_RUN;
        end else if (bus.hold) begin
            // Freeze everything: state and counters keep their values
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (taken) begin
                        pc_src_c   = 1'b1;
                        flush_c    = 1'b1;
                        cnt_inc[1] = 1'b1;
                        state_next = ST_FLUSH;
                    end else if (load_use) begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_bubble_c = 1'b1;
                        cnt_inc[0]    = 1'b1;
                        state_next    = ST_STALL;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
                ST_STALL: begin
                    // Load-use is masked here so stalls never chain back to back
                    if (taken) begin
                        pc_src_c   = 1'b1;
                        flush_c    = 1'b1;
                        cnt_inc[1] = 1'b1;
                        state_next = ST_FLUSH;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    // FLUSH and the unused encoding both fall back to RUN
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= 16'd0;
                end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign bus.pc_write    = pc_write_c;
    assign bus.ifid_write  = ifid_write_c;
    assign bus.idex_bubble = idex_bubble_c;
    assign bus.pc_src      = pc_src_c;
    assign bus.flush_ifid  = flush_c;
    assign bus.flush_idex  = flush_c;
    assign bus.flush_exmem = flush_c;
    assign bus.state       = state_reg;
    assign bus.stall_cnt   = g_cnt[0].cnt_reg;
    assign bus.flush_cnt   = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against an event-level reference model.
module tb_hazard_ctrl;

    localparam logic [15:0] SAT = 16'd40;

    logic clk;
    logic reset;
    hazard_ctrl_if bus ();

    hazard_ctrl #(.CNT_MAX(SAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what happened on the previous accepted cycle
    localparam int EV_NONE = 0, EV_STALL = 1, EV_FLUSH = 2;
    int last_ev = EV_NONE;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c < int'(SAT)) ? c + 1 : c;
    endfunction

    // Drive one cycle of inputs, check combinational outputs and current
    // state/counters against the model, then advance the model.
    task automatic step(input bit rst, input bit h, input bit mr,
                        input logic [4:0] irt, input logic [4:0] rs, input logic [4:0] rt,
                        input bit br, input bit z);
        bit lu, tk;
        bit e_pcw, e_ifw, e_bub, e_src, e_fl;
        int ev;
        @(negedge clk);
        reset            = rst;
        bus.hold         = h;
        bus.idex_memread = mr;
        bus.idex_rt      = irt;
        bus.ifid_rs      = rs;
        bus.ifid_rt      = rt;
        bus.exmem_branch = br;
        bus.exmem_zero   = z;
        #1;
        lu = mr && (irt != 0) && (irt == rs || irt == rt);
        tk = br && z;
        e_pcw = 1; e_ifw = 1; e_bub = 0; e_src = 0; e_fl = 0;
        ev = last_ev;
        if (rst) begin
            e_pcw = 0; e_ifw = 0;
        end else if (h) begin
            e_pcw = 0; e_ifw = 0;
        end else if (last_ev == EV_FLUSH) begin
            ev = EV_NONE;
        end else if (tk) begin
            e_src = 1; e_fl = 1; ev = EV_FLUSH;
        end else if (lu && last_ev != EV_STALL) begin
            e_pcw = 0; e_ifw = 0; e_bub = 1; ev = EV_STALL;
        end else begin
            ev = EV_NONE;
        end

        check("state", 32'(bus.state), 32'(last_ev));
        check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
        check("ctrl", {25'd0, bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.pc_src,
                       bus.flush_ifid, bus.flush_idex, bus.flush_exmem},
              {25'd0, e_pcw, e_ifw, e_bub, e_src, e_fl, e_fl, e_fl});

        if (rst) begin
            last_ev = EV_NONE; m_stall = 0; m_flush = 0;
        end else if (!h) begin
            if (ev == EV_STALL) m_stall = sat_inc(m_stall);
            if (ev == EV_FLUSH && last_ev != EV_FLUSH) m_flush = sat_inc(m_flush);
            last_ev = ev;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.hold = 0; bus.idex_memread = 0; bus.idex_rt = 0; bus.ifid_rs = 0;
        bus.ifid_rt = 0; bus.exmem_branch = 0; bus.exmem_zero = 0;

        // Reset state
        step(1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 1);
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();

        // Load-use stall on rs match
        step(0, 0, 1, 5'd5, 5'd5, 5'd9, 0, 0);
        after_edge();
        check("lu_state", 32'(bus.state), 32'd1);
        check("lu_cnt", 32'(bus.stall_cnt), 32'd1);
        step(0, 0, 1, 5'd5, 5'd5, 5'd9, 0, 0);
        idle();

        // r0 never stalls
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
        after_edge();
        check("r0_cnt", 32'(bus.stall_cnt), 32'd0);

        // Branch wins over load-use in the same cycle
        step(0, 0, 1, 5'd7, 5'd3, 5'd7, 1, 1);
        after_edge();
        check("br_state", 32'(bus.state), 32'd2);
        check("br_fcnt", 32'(bus.flush_cnt), 32'd1);
        check("br_scnt", 32'(bus.stall_cnt), 32'd0);
        idle();

        // taken held two cycles: second one masked by FLUSH
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1);
        step(0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1);
        idle();
        check("mask_fcnt", 32'(bus.flush_cnt), 32'd2);

        // hold freezes a pending load-use, then it stalls on release
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 5'd4, 5'd1, 5'd4, 0, 0);
        after_edge();
        check("hold_state", 32'(bus.state), 32'd0);
        check("hold_cnt", 32'(bus.stall_cnt), 32'd0);
        step(0, 0, 1, 5'd4, 5'd1, 5'd4, 0, 0);
        idle();

        // Continuous load-use until the stall counter saturates
        step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 2 * int'(SAT) + 10; i++) step(0, 0, 1, 5'd2, 5'd2, 5'd2, 0, 0);
        after_edge();
        check("sat_cnt", 32'(bus.stall_cnt), 32'(SAT));

        // Reset in the middle of a stall aborts it
        idle();
        step(0, 0, 1, 5'd6, 5'd6, 5'd0, 0, 0);
        step(1, 0, 1, 5'd6, 5'd6, 5'd0, 0, 0);
        after_edge();
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_cnt", 32'(bus.stall_cnt), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
